mem_writeback_unit: RTL

Parametrised memory-access and register-writeback stage for the pipelined RISC-V core, placed after the ALU and before the register file and PC mux. Accepts one decoded operation per handshake and performs, by operation class, ALU writeback, LUI writeback, branch or jump PC redirect, or a byte/half/word load or store. Unlike the previous single-cycle controller, it drives a variable-latency data memory over a req/ack handshake with timeout, builds byte strobes, sign/zero-extends loads and flags misaligned or illegal accesses. It also publishes a forwarding port.

---
 rtl/mem_wb_pkg.sv | 56 +++++
 rtl/store_align.sv | 36 +++
 rtl/mem_writeback_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory/writeback stage: op and funct3 encodings,
// FSM states and the load sign/zero-extension helper.
package mem_wb_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_ALU    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_LUI    = 3'd6;
    localparam logic [2:0] OP_ILL    = 3'd7;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is funct3[1:0] for both loads and stores
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_LDWB = 2'd2
    } wb_state_t;

    function automatic logic load_legal(input logic [2:0] func3);
        return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
               (func3 == F3_BU) || (func3 == F3_HU);
    endfunction

    function automatic logic store_legal(input logic [2:0] func3);
        return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  func3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rdata >> {lane, 3'b000};
        half    = lane[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   return {24'd0, shifted[7:0]};
            F3_H:    return {{16{half[15]}}, half};
            F3_HU:   return {16'd0, half};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte strobes, lane-replicated write data
// and the misalignment flag for a given access size and address offset.
module store_align
    import mem_wb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] sdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        wstrb    = 4'b0000;
        wdata    = sdata;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                wstrb = 4'b0001 << lane;
                wdata = {4{sdata[7:0]}};
            end
            SZ_H: begin
                wstrb    = lane[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata[15:0]}};
                misalign = lane[0];
            end
            SZ_W: begin
                wstrb    = 4'b1111;
                misalign = (lane != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_writeback_unit.sv
// Memory-access and register-writeback stage: ALU/LUI/JUMP writeback, branch
// redirect, and variable-latency loads/stores over a req/ack bus with timeout.
module mem_writeback_unit
    import mem_wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int RA_W        = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_func3,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_sdata,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [RA_W-1:0]   in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_wdata,
    output logic              fwd_valid,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              err_misalign,
    output logic              err_bus,
    output logic              err_illegal
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    wb_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              pc_we_q, pc_we_d;
    logic [ADDR_W-1:0] pc_wdata_q, pc_wdata_d;
    logic              err_misalign_q, err_misalign_d;
    logic              err_bus_q, err_bus_d;
    logic              err_illegal_q, err_illegal_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [2:0]        ld_func3_q, ld_func3_d;
    logic [1:0]        ld_lane_q, ld_lane_d;
    logic [RA_W-1:0]   ld_rd_q, ld_rd_d;

    logic [3:0]        sa_wstrb;
    logic [XLEN-1:0]   sa_wdata;
    logic              sa_misalign;
    logic [ADDR_W-1:0] addr_a;
    logic              accept;

    store_align u_store_align (
        .size     (in_func3[1:0]),
        .lane     (in_alu[1:0]),
        .sdata    (in_sdata),
        .wstrb    (sa_wstrb),
        .wdata    (sa_wdata),
        .misalign (sa_misalign)
    );

    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign addr_a   = ADDR_W'(in_alu);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        pc_we_d        = 1'b0;
        pc_wdata_d     = pc_wdata_q;
        err_misalign_d = 1'b0;
        err_bus_d      = 1'b0;
        err_illegal_d  = 1'b0;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        ld_func3_d     = ld_func3_q;
        ld_lane_d      = ld_lane_q;
        ld_rd_d        = ld_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (in_op)
                        OP_ALU: begin
                            rf_we_d    = (in_rd != '0);
                            rf_waddr_d = in_rd;
                            rf_wdata_d = in_alu;
                        end
                        OP_LUI: begin
                            rf_we_d    = (in_rd != '0);
                            rf_waddr_d = in_rd;
                            rf_wdata_d = in_imm;
                        end
                        OP_BRANCH: begin
                            if (in_alu != '0) begin
                                pc_we_d    = 1'b1;
                                pc_wdata_d = in_pc + ADDR_W'(in_imm);
                            end
                        end
                        OP_JUMP: begin
                            pc_we_d    = 1'b1;
                            pc_wdata_d = addr_a & ~ADDR_W'(1);
                            rf_we_d    = (in_rd != '0);
                            rf_waddr_d = in_rd;
                            rf_wdata_d = XLEN'(in_pc + ADDR_W'(4));
                        end
                        OP_LOAD, OP_STORE: begin
                            // Illegal funct3 takes priority over alignment
                            if ((in_op == OP_LOAD) ? !load_legal(in_func3)
                                                   : !store_legal(in_func3)) begin
                                err_illegal_d = 1'b1;
                            end else if (sa_misalign) begin
                                err_misalign_d = 1'b1;
                            end else begin
                                state_d     = ST_MEM;
                                cnt_d       = '0;
                                mem_req_d   = 1'b1;
                                mem_we_d    = (in_op == OP_STORE);
                                mem_addr_d  = addr_a & ~ADDR_W'(3);
                                mem_wdata_d = (in_op == OP_STORE) ? sa_wdata : '0;
                                mem_wstrb_d = (in_op == OP_STORE) ? sa_wstrb : 4'b0000;
                                ld_func3_d  = in_func3;
                                ld_lane_d   = in_alu[1:0];
                                ld_rd_d     = in_rd;
                            end
                        end
                        OP_ILL: err_illegal_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_LDWB;
                        rf_we_d    = (ld_rd_q != '0);
                        rf_waddr_d = ld_rd_q;
                        rf_wdata_d = XLEN'(load_extend(ld_func3_q, ld_lane_q, 32'(mem_rdata)));
                    end
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    err_bus_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LDWB: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            pc_we_q        <= 1'b0;
            pc_wdata_q     <= '0;
            err_misalign_q <= 1'b0;
            err_bus_q      <= 1'b0;
            err_illegal_q  <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
            ld_func3_q     <= '0;
            ld_lane_q      <= '0;
            ld_rd_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            pc_we_q        <= pc_we_d;
            pc_wdata_q     <= pc_wdata_d;
            err_misalign_q <= err_misalign_d;
            err_bus_q      <= err_bus_d;
            err_illegal_q  <= err_illegal_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            ld_func3_q     <= ld_func3_d;
            ld_lane_q      <= ld_lane_d;
            ld_rd_q        <= ld_rd_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign pc_we        = pc_we_q;
    assign pc_wdata     = pc_wdata_q;
    assign fwd_valid    = rf_we_q;
    assign fwd_rd       = rf_waddr_q;
    assign fwd_data     = rf_wdata_q;
    assign err_misalign = err_misalign_q;
    assign err_bus      = err_bus_q;
    assign err_illegal  = err_illegal_q;

endmodule
